// File: rtl/rrc_matched_filter_if.sv
`timescale 1ns/1ps
// rrc_matched_filter_if: I/Q sample stream into the matched filter and filtered stream out
interface rrc_matched_filter_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] i_in;
  logic signed [DATA_W-1:0] q_in;
  logic signed [DATA_W-1:0] i_out;
  logic signed [DATA_W-1:0] q_out;
  logic iq_val_i;
  logic iq_val_o;
  modport master (output i_in, q_in, iq_val_i, input i_out, q_out, iq_val_o);
  modport slave (input i_in, q_in, iq_val_i, output i_out, q_out, iq_val_o);
endinterface

// File: rtl/rrc_matched_filter.sv
`timescale 1ns/1ps
// rrc_matched_filter: 33-tap symmetric RRC matched filter on independent I/Q streams, 3-cycle latency
module rrc_matched_filter #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int COEF_FRAC = 15
) (
  input logic clk,
  input logic rst,
  rrc_matched_filter_if.slave s
);
  localparam int NUM_TAPS = 33;
  localparam int HALF = NUM_TAPS / 2;
  localparam int ACC_W = DATA_W + COEF_W + 6;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - 1;
  // RRC(0.35, 8 sps, 4 symbols) taps 0..16 in Q1.15; taps 17..32 mirror these
  localparam logic signed [COEF_W-1:0] H [HALF+1] = '{
    16'sd854, 16'sd384, -16'sd330, -16'sd1186, -16'sd2021, -16'sd2635, -16'sd2821, -16'sd2401,
    -16'sd1266, 16'sd597, 16'sd3093, 16'sd6020, 16'sd9089, 16'sd11964, 16'sd14328, 16'sd15849,
    16'sd16384
  };
  logic signed [DATA_W-1:0] xi [NUM_TAPS];
  logic signed [DATA_W-1:0] xq [NUM_TAPS];
  logic signed [DATA_W:0] si [HALF+1];
  logic signed [DATA_W:0] sq [HALF+1];
  logic signed [PROD_W-1:0] pi [HALF+1];
  logic signed [PROD_W-1:0] pq [HALF+1];
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [DATA_W-1:0] yi;
  logic signed [DATA_W-1:0] yq;
  logic [2:0] vld;

  function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = (a + ACC_W'(1 << (COEF_FRAC - 1))) >>> COEF_FRAC;
    return r > Y_MAX ? Y_MAX[DATA_W-1:0] : r < Y_MIN ? Y_MIN[DATA_W-1:0] : r[DATA_W-1:0];
  endfunction

  // symmetric pre-add: the centre tap has no mirror partner
  always_comb begin
    acc_i = '0;
    acc_q = '0;
    for (int k = 0; k <= HALF; k++) begin
      si[k] = (DATA_W+1)'(xi[k]) + (k == HALF ? (DATA_W+1)'(0) : (DATA_W+1)'(xi[NUM_TAPS-1-k]));
      sq[k] = (DATA_W+1)'(xq[k]) + (k == HALF ? (DATA_W+1)'(0) : (DATA_W+1)'(xq[NUM_TAPS-1-k]));
      acc_i = acc_i + ACC_W'(pi[k]);
      acc_q = acc_q + ACC_W'(pq[k]);
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      xi <= '{default: '0};
      xq <= '{default: '0};
      pi <= '{default: '0};
      pq <= '{default: '0};
      yi <= '0;
      yq <= '0;
      vld <= '0;
    end else begin
      vld <= {vld[1:0], s.iq_val_i};
      if (s.iq_val_i) begin
        xi[0] <= s.i_in;
        xq[0] <= s.q_in;
        for (int k = 1; k < NUM_TAPS; k++) begin
          xi[k] <= xi[k-1];
          xq[k] <= xq[k-1];
        end
      end
      if (vld[0])
        for (int k = 0; k <= HALF; k++) begin
          pi[k] <= PROD_W'(si[k]) * PROD_W'(H[k]);
          pq[k] <= PROD_W'(sq[k]) * PROD_W'(H[k]);
        end
      if (vld[1]) begin
        yi <= scale(acc_i);
        yq <= scale(acc_q);
      end
    end

  assign s.i_out = yi;
  assign s.q_out = yq;
  assign s.iq_val_o = vld[2];
endmodule

// File: tb/tb_rrc_matched_filter.sv
`timescale 1ns/1ps
// tb_rrc_matched_filter: scoreboard bench for the I/Q RRC matched filter
module tb_rrc_matched_filter;
  typedef struct { int i; int q; } pair_t;
  logic clk = 0;
  logic rst = 0;
  int errors = 0;
  int checks = 0;
  int H [17] = '{854, 384, -330, -1186, -2021, -2635, -2821, -2401, -1266, 597, 3093, 6020,
                 9089, 11964, 14328, 15849, 16384};
  int xi_h [33];
  int xq_h [33];
  int obs_i [$];
  int obs_q [$];
  pair_t sb [$];
  pair_t mp;
  logic [2:0] vpipe;
  int last_i;
  int last_q;

  rrc_matched_filter_if #(.DATA_W(16)) bus ();
  rrc_matched_filter dut (.clk(clk), .rst(rst), .s(bus));

  always #5 clk = ~clk;

  function automatic int coef(input int k);
    return H[k <= 16 ? k : 32 - k];
  endfunction

  function automatic int filt(input bit q_ch);
    longint acc = 0;
    for (int k = 0; k < 33; k++) acc += longint'(coef(k)) * longint'(q_ch ? xq_h[k] : xi_h[k]);
    acc = (acc + 16384) >>> 15;
    return acc > 32767 ? 32767 : acc < -32768 ? -32768 : int'(acc);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input bit v, input int i, input int q);
    pair_t p;
    @(negedge clk);
    bus.iq_val_i = v;
    bus.i_in = 16'(i);
    bus.q_in = 16'(q);
    if (v) begin
      for (int k = 32; k > 0; k--) begin
        xi_h[k] = xi_h[k-1];
        xq_h[k] = xq_h[k-1];
      end
      xi_h[0] = i;
      xq_h[0] = q;
      p.i = filt(0);
      p.q = filt(1);
      sb.push_back(p);
    end
  endtask

  task automatic drain();
    int n = 0;
    send(0, 0, 0);
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain pending outputs", sb.size(), 0);
  endtask

  task automatic reset_zero_checks(input string tag);
    check({tag, " i_out"}, int'(bus.i_out), 0);
    check({tag, " q_out"}, int'(bus.q_out), 0);
    check({tag, " iq_val_o"}, int'(bus.iq_val_o), 0);
  endtask

  task automatic hold_reset();
    sb.delete();
    xi_h = '{default: 0};
    xq_h = '{default: 0};
    repeat (3) begin
      @(negedge clk);
      bus.iq_val_i = 1;
      bus.i_in = 16'($urandom);
      bus.q_in = 16'($urandom);
      #1 reset_zero_checks("in reset");
    end
    @(negedge clk);
    rst = 0;
    bus.iq_val_i = 0;
  endtask

  task automatic impulse(input int qa, input bit gaps, input string tag);
    obs_i.delete();
    obs_q.delete();
    send(1, 32767, qa);
    for (int n = 0; n < 40; n++) begin
      if (gaps) send(0, 1234, -77);
      send(1, 0, 0);
    end
    drain();
    check({tag, " output count"}, obs_i.size(), 41);
    if (obs_i.size() >= 41) begin
      for (int k = 0; k < 33; k++) begin
        check({tag, " i tap"}, obs_i[k], coef(k));
        check({tag, " q tap"}, obs_q[k], qa == 0 ? 0 : coef(k));
      end
      check({tag, " i peak"}, obs_i[16], 16384);
      for (int k = 0; k < 16; k++) check({tag, " i symmetry"}, obs_i[k], obs_i[32-k]);
      for (int k = 33; k < 41; k++) check({tag, " i tail"}, obs_i[k], 0);
    end
  endtask

  always @(posedge clk or posedge rst)
    if (rst) vpipe <= '0;
    else vpipe <= {vpipe[1:0], bus.iq_val_i};

  always @(negedge clk) begin
    if (rst) begin
      last_i = 0;
      last_q = 0;
    end else begin
      check("iq_val_o latency", int'(bus.iq_val_o), int'(vpipe[2]));
      if (bus.iq_val_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected output: got i=%0d q=%0d, expected none", bus.i_out, bus.q_out);
        end else begin
          mp = sb.pop_front();
          check("i_out", int'(bus.i_out), mp.i);
          check("q_out", int'(bus.q_out), mp.q);
        end
        obs_i.push_back(int'(bus.i_out));
        obs_q.push_back(int'(bus.q_out));
        last_i = int'(bus.i_out);
        last_q = int'(bus.q_out);
      end else begin
        check("i_out hold", int'(bus.i_out), last_i);
        check("q_out hold", int'(bus.q_out), last_q);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.iq_val_i = 0;
    bus.i_in = 0;
    bus.q_in = 0;
    #1 rst = 1;
    #1 reset_zero_checks("power-on reset");
    hold_reset();
    impulse(32767, 0, "impulse");
    obs_i.delete();
    obs_q.delete();
    for (int n = 0; n < 20; n++) send(1, 32767, 32767);
    for (int n = 0; n < 40; n++) send(1, 0, 0);
    drain();
    check("step count", obs_i.size(), 60);
    if (obs_i.size() >= 53) begin
      check("step first", obs_i[0], 854);
      check("step last nonzero", obs_i[51], 854);
      check("step i back to 0", obs_i[52], 0);
      check("step q back to 0", obs_q[52], 0);
    end
    impulse(0, 0, "independence");
    impulse(32767, 1, "gaps");
    obs_i.delete();
    obs_q.delete();
    for (int n = 0; n < 40; n++) send(1, -32768, 32767);
    check("saturation enough outputs", int'(obs_i.size() >= 36), 1);
    if (obs_i.size() >= 36) begin
      check("saturation i", obs_i[35], -32768);
      check("saturation q", obs_q[35], 32767);
    end
    @(posedge clk);
    #2 rst = 1;
    #1 reset_zero_checks("async mid-run reset");
    hold_reset();
    impulse(32767, 0, "post-reset impulse");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rrc_matched_filter.md
Name: rrc_matched_filter

Overview:
Receive-side root-raised-cosine (RRC) matched filter for the MSK modem RX path.
- Filters the I and Q baseband streams independently with the same fixed, symmetric FIR coefficient set.
- Sits between the front-end sample source and the timing-recovery/demod logic.
- Fixed pipeline latency; sample-enable driven by a shared I/Q valid strobe.

Parameters:
DATA_W, 16, signed width of i_in/q_in/i_out/q_out
COEF_W, 16, signed coefficient width, fractional format Q1.15 (COEF_FRAC=15)
NUM_TAPS, 33, filter length (SPS=8, span 4 symbols, odd, symmetric)
ROLLOFF, 0.35, RRC roll-off used to generate the coefficient table offline
LATENCY, 3, clk cycles from accepted input to corresponding output

Ports:
clk  in  1  system clock (200 MHz target)
rst  in  1  asynchronous active-high reset
i_in  in  DATA_W  signed in-phase sample
q_in  in  DATA_W  signed quadrature sample
iq_val_i  in  1  i_in/q_in valid, one sample per asserted cycle
i_out  out  DATA_W  signed filtered in-phase sample
q_out  out  DATA_W  signed filtered quadrature sample
iq_val_o  out  1  i_out/q_out valid

Behaviour:
- Interface: single clock clk; reset rst is asynchronous and active-high.
- Reset: all tap delay lines, pipeline registers, i_out, q_out cleared to 0; iq_val_o=0. Reset mid-stream discards all history; the first post-reset output reflects only post-reset inputs (zero-padded).
- Coefficients: constant table h[0..NUM_TAPS-1], symmetric h[k]=h[NUM_TAPS-1-k], center h[16]=16384 (0.5 in Q1.15), generated offline from RRC(ROLLOFF, SPS=8). The same table is used by the verification model.
- Sample advance: delay lines shift only on cycles with iq_val_i=1. With iq_val_i=0 the state holds, and no output is produced for that cycle.
- Arithmetic per channel: acc = sum_k h[k]*x[n-k], computed at full precision (DATA_W+COEF_W+6 = 38 bits, no intermediate truncation).
- Output scaling: y = sat_DATA_W((acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC), i.e. round-half-up then saturate to [-32768, 32767].
- I and Q paths are identical and fully independent. There is no cross-coupling.
- Latency: iq_val_o(t+LATENCY) = iq_val_i(t). i_out/q_out carry the result for the sample accepted at t.
- Throughput: one sample per clk; back-to-back valid is supported.
- When iq_val_o=0, i_out/q_out hold their last value.
- Pipeline: free choice of implementation (pre-added symmetric direct form or transposed form), provided latency and bit-exact results match the above.
- X/undefined iq_val_i before first drive: no requirement beyond reset state.

Test Plan:
1. Reset: assert rst with clk running and random inputs -> i_out=q_out=0, iq_val_o=0 immediately (asynchronous) and throughout reset.
2. Impulse: iq_val_i=1 continuously, one-cycle i_in=q_in=32767, zeros otherwise. Required response:
   - 33 consecutive outputs starting LATENCY cycles later equal round(32767*h[k]/32768), k=0..32.
   - Peak at k=16 equals 16384 on both I and Q.
   - Symmetric about the peak; all subsequent outputs 0.
3. Step burst: i_in=q_in=32767 for 20 consecutive valid cycles, then 0. Required response:
   - Outputs match the bit-exact model (partial coefficient sums x32767, rounded, saturated).
   - Output returns to 0 exactly 20+32 samples after the burst start.
4. Channel independence: impulse of 32767 on i_in only, q_in=0 -> q_out=0 always; i_out equals scenario 2.
5. Valid gaps: impulse with iq_val_i toggling 1010… -> output sequence equals scenario 2 when indexed by valid samples only. iq_val_o follows iq_val_i delayed by exactly LATENCY.
6. Saturation/negative: sustained i_in=-32768, q_in=32767 for ≥33 samples -> steady-state outputs match the model, clamped to -32768/32767 if the DC gain exceeds 1. Reset asserted mid-run -> outputs 0, then a clean impulse response afterwards.
